// File: rtl/control_unit.sv
// Instruction-sequencing control unit: a Moore FSM that walks fetch (T0-T2)
// and opcode-dependent execute steps (T3-T6), emitting Datapath strobes.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        pc_out,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        mdr_out,
    output logic        mar_enable,
    output logic        mdr_enable,
    output logic        ir_enable,
    output logic        y_enable,
    output logic        z_enable,
    output logic        lo_enable,
    output logic        hi_enable,
    output logic        pc_increment,
    output logic        read,
    output logic [4:0]  op_code,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic        run
);

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [4:0] opcode;
    logic       is_alu3;
    logic       is_unary;
    logic       is_muldiv;
    logic       is_halt;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    // Register fields are consumed by the Datapath's select-and-encode logic.
    assign unused_ir = ^ir[26:0];

    always_comb begin
        is_alu3   = 1'b0;
        is_unary  = 1'b0;
        is_muldiv = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: is_alu3   = 1'b1;
            5'b10001, 5'b10010:                     is_unary  = 1'b1;
            5'b01111, 5'b10000:                     is_muldiv = 1'b1;
            5'b11011:                               is_halt   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = mem_ready ? ST_T2 : ST_T1;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (is_alu3 || is_unary || is_muldiv) begin
                    state_d = ST_T4;
                end else if (is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T4:   state_d = (is_alu3 || is_muldiv) ? ST_T5 : ST_T0;
            ST_T5:   state_d = is_muldiv ? ST_T6 : ST_T0;
            ST_T6:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // Outputs depend only on state and the (stable) instruction register.
    always_comb begin
        pc_out       = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        mdr_out      = 1'b0;
        mar_enable   = 1'b0;
        mdr_enable   = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        z_enable     = 1'b0;
        lo_enable    = 1'b0;
        hi_enable    = 1'b0;
        pc_increment = 1'b0;
        read         = 1'b0;
        op_code      = 5'b00000;
        gra          = 1'b0;
        grb          = 1'b0;
        grc          = 1'b0;
        r_in         = 1'b0;
        r_out        = 1'b0;
        run          = 1'b1;
        case (state_q)
            ST_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
            end
            ST_T1: begin
                read       = 1'b1;
                mdr_enable = 1'b1;
            end
            ST_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            ST_T3: begin
                if (is_alu3) begin
                    grb      = 1'b1;
                    r_out    = 1'b1;
                    y_enable = 1'b1;
                end else if (is_unary) begin
                    grb      = 1'b1;
                    r_out    = 1'b1;
                    z_enable = 1'b1;
                    op_code  = opcode;
                end else if (is_muldiv) begin
                    gra      = 1'b1;
                    r_out    = 1'b1;
                    y_enable = 1'b1;
                end
            end
            ST_T4: begin
                if (is_alu3) begin
                    grc      = 1'b1;
                    r_out    = 1'b1;
                    z_enable = 1'b1;
                    op_code  = opcode;
                end else if (is_unary) begin
                    zlo_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else if (is_muldiv) begin
                    grb      = 1'b1;
                    r_out    = 1'b1;
                    z_enable = 1'b1;
                    op_code  = opcode;
                end
            end
            ST_T5: begin
                if (is_alu3) begin
                    zlo_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else if (is_muldiv) begin
                    zlo_out   = 1'b1;
                    lo_enable = 1'b1;
                end
            end
            ST_T6: begin
                zhi_out   = 1'b1;
                hi_enable = 1'b1;
            end
            ST_HALT: run = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a per-instruction micro-step model feeds a
// queue of expected output words that a compare process checks every cycle.
module tb_control_unit;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        mem_ready;
    logic        pc_out, zlo_out, zhi_out, mdr_out;
    logic        mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
    logic        lo_enable, hi_enable, pc_increment, read;
    logic [4:0]  op_code;
    logic        gra, grb, grc, r_in, r_out, run;

    control_unit dut (
        .clk          (clk),
        .clr          (clr),
        .ir           (ir),
        .mem_ready    (mem_ready),
        .pc_out       (pc_out),
        .zlo_out      (zlo_out),
        .zhi_out      (zhi_out),
        .mdr_out      (mdr_out),
        .mar_enable   (mar_enable),
        .mdr_enable   (mdr_enable),
        .ir_enable    (ir_enable),
        .y_enable     (y_enable),
        .z_enable     (z_enable),
        .lo_enable    (lo_enable),
        .hi_enable    (hi_enable),
        .pc_increment (pc_increment),
        .read         (read),
        .op_code      (op_code),
        .gra          (gra),
        .grb          (grb),
        .grc          (grc),
        .r_in         (r_in),
        .r_out        (r_out),
        .run          (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: {op_code[4:0], 19 single-bit strobes}
    localparam logic [23:0] M_PC_OUT  = 24'h000001;
    localparam logic [23:0] M_ZLO     = 24'h000002;
    localparam logic [23:0] M_ZHI     = 24'h000004;
    localparam logic [23:0] M_MDR_OUT = 24'h000008;
    localparam logic [23:0] M_MAR_EN  = 24'h000010;
    localparam logic [23:0] M_MDR_EN  = 24'h000020;
    localparam logic [23:0] M_IR_EN   = 24'h000040;
    localparam logic [23:0] M_Y_EN    = 24'h000080;
    localparam logic [23:0] M_Z_EN    = 24'h000100;
    localparam logic [23:0] M_LO_EN   = 24'h000200;
    localparam logic [23:0] M_HI_EN   = 24'h000400;
    localparam logic [23:0] M_PC_INC  = 24'h000800;
    localparam logic [23:0] M_READ    = 24'h001000;
    localparam logic [23:0] M_GRA     = 24'h002000;
    localparam logic [23:0] M_GRB     = 24'h004000;
    localparam logic [23:0] M_GRC     = 24'h008000;
    localparam logic [23:0] M_R_IN    = 24'h010000;
    localparam logic [23:0] M_R_OUT   = 24'h020000;
    localparam logic [23:0] M_RUN     = 24'h040000;

    localparam logic [23:0] W_RST  = M_RUN;
    localparam logic [23:0] W_HALT = 24'h000000;
    localparam logic [23:0] W_T0   = M_RUN | M_PC_OUT | M_MAR_EN | M_PC_INC;
    localparam logic [23:0] W_T1   = M_RUN | M_READ | M_MDR_EN;
    localparam logic [23:0] W_T2   = M_RUN | M_MDR_OUT | M_IR_EN;

    logic [23:0] act;
    assign act = {op_code, run, r_out, r_in, grc, grb, gra, read, pc_increment,
                  hi_enable, lo_enable, z_enable, y_enable, ir_enable, mdr_enable,
                  mar_enable, mdr_out, zhi_out, zlo_out, pc_out};

    typedef struct {
        logic [23:0] w;
        string       tag;
    } exp_t;

    typedef struct {
        string tag;
        int    got;
        int    want;
    } pin_t;

    exp_t exp_q[$];
    pin_t pin_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Sole checker: model pins and per-cycle output words, sampled mid-cycle.
    initial begin
        exp_t e;
        pin_t p;
        forever begin
            @(negedge clk);
            while (pin_q.size() > 0) begin
                p = pin_q.pop_front();
                n_cmp++;
                if (p.got != p.want) begin
                    n_bad++;
                    $display("FAIL len %s: got %0d cycles, want %0d", p.tag, p.got, p.want);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (act !== e.w) begin
                    n_bad++;
                    $display("FAIL outputs %s @%0t: got %h want %h", e.tag, $time, act, e.w);
                end
            end
        end
    end

    task automatic cyc(input logic [23:0] w, input logic mr, input string tag);
        exp_t e;
        mem_ready = mr;
        e.w   = w;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 with the DUT in T0; returns at posedge+1 after the
    // last modelled step.
    task automatic run_instr(input logic [31:0] iv, input int waits,
                             input int want_len, input string tag);
        int          n;
        logic [4:0]  op;
        logic [23:0] opw;
        pin_t        p;
        n   = 0;
        ir  = iv;
        op  = iv[31:27];
        opw = {op, 19'b0};
        cyc(W_T0, 1'b1, {tag, " T0"}); n++;
        for (int i = 0; i < waits; i++) begin
            cyc(W_T1, 1'b0, {tag, " T1wait"}); n++;
        end
        cyc(W_T1, 1'b1, {tag, " T1"}); n++;
        cyc(W_T2, 1'b1, {tag, " T2"}); n++;
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
                cyc(M_RUN | M_GRB | M_R_OUT | M_Y_EN, 1'b1, {tag, " T3"});
                cyc(M_RUN | M_GRC | M_R_OUT | M_Z_EN | opw, 1'b1, {tag, " T4"});
                cyc(M_RUN | M_ZLO | M_GRA | M_R_IN, 1'b1, {tag, " T5"});
                n += 3;
            end
            5'd17, 5'd18: begin
                cyc(M_RUN | M_GRB | M_R_OUT | M_Z_EN | opw, 1'b1, {tag, " T3"});
                cyc(M_RUN | M_ZLO | M_GRA | M_R_IN, 1'b1, {tag, " T4"});
                n += 2;
            end
            5'd15, 5'd16: begin
                cyc(M_RUN | M_GRA | M_R_OUT | M_Y_EN, 1'b1, {tag, " T3"});
                cyc(M_RUN | M_GRB | M_R_OUT | M_Z_EN | opw, 1'b1, {tag, " T4"});
                cyc(M_RUN | M_ZLO | M_LO_EN, 1'b1, {tag, " T5"});
                cyc(M_RUN | M_ZHI | M_HI_EN, 1'b1, {tag, " T6"});
                n += 4;
            end
            5'd27: begin
                cyc(M_RUN, 1'b1, {tag, " T3"});
                n++;
                for (int i = 0; i < 12; i++) begin
                    cyc(W_HALT, 1'b1, {tag, " HALT"}); n++;
                end
            end
            default: begin
                cyc(M_RUN, 1'b1, {tag, " T3"});
                n++;
            end
        endcase
        p.tag  = tag;
        p.got  = n;
        p.want = want_len;
        pin_q.push_back(p);
    endtask

    // Short clr pulse between edges; the next negedge sample must show RST.
    task automatic clr_pulse(input string tag);
        #2;
        clr = 1'b0;
        #1;
        clr = 1'b1;
        cyc(W_RST, 1'b1, {tag, " RST"});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        clr       = 1'b0;
        ir        = 32'h0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc(W_RST, 1'b1, "reset held");
        cyc(W_RST, 1'b1, "reset held");
        clr = 1'b1;
        cyc(W_RST, 1'b1, "reset release");

        run_instr(32'h92800000, 0, 5,  "not");
        run_instr(32'h18918000, 0, 6,  "add");
        run_instr(32'h20918000, 3, 9,  "sub wait3");
        run_instr(32'h79100000, 0, 7,  "mul");
        run_instr(32'h80000000, 1, 8,  "div wait1");
        run_instr(32'h88000000, 0, 5,  "neg");
        run_instr(32'h48000000, 0, 6,  "ror");
        run_instr(32'hD0000000, 0, 4,  "nop");
        run_instr(32'h00000000, 0, 4,  "undef 00000");
        run_instr(32'h58000000, 0, 4,  "undef 01011");
        run_instr(32'hF8000000, 0, 4,  "undef 11111");

        // Abort an add in T4, then confirm a clean restart from T0.
        ir = 32'h18918000;
        cyc(W_T0, 1'b1, "abort T0");
        cyc(W_T1, 1'b1, "abort T1");
        cyc(W_T2, 1'b1, "abort T2");
        cyc(M_RUN | M_GRB | M_R_OUT | M_Y_EN, 1'b1, "abort T3");
        clr_pulse("abort");
        run_instr(32'h18918000, 0, 6, "add after abort");

        run_instr(32'hD8000000, 0, 16, "halt");
        clr_pulse("halt exit");
        run_instr(32'h92800000, 2, 7, "not after halt");

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
